vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync and visible-area flags,
// line/frame strobes and a frame counter, all advanced by a pixel-clock enable.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PIPE      = 0,
    parameter int CW        = 10,
    parameter int FW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic h_last;
    logic v_last;
    logic hs_raw;
    logic vs_raw;
    logic de_raw;

    // Stage 0 is the mandatory output register; stages 1..PIPE add latency.
    logic [PIPE:0] hs_q;
    logic [PIPE:0] vs_q;
    logic [PIPE:0] de_q;

    assign h_last = (hpos == H_LAST);
    assign v_last = (vpos == V_LAST);

    always_comb begin
        hs_raw = ~HSYNC_POL;
        vs_raw = ~VSYNC_POL;
        de_raw = 1'b0;
        if (hpos >= HS_BEG && hpos <= HS_END)
            hs_raw = HSYNC_POL;
        if (vpos >= VS_BEG && vpos <= VS_END)
            vs_raw = VSYNC_POL;
        if (hpos < H_ACT && vpos < V_ACT)
            de_raw = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hpos <= '0;
            vpos <= '0;
        end else if (ce) begin
            if (h_last) begin
                hpos <= '0;
                vpos <= v_last ? '0 : vpos + CW'(1);
            end else begin
                hpos <= hpos + CW'(1);
            end
        end
    end

    // Strobes are cleared on every non-ce clk so they stay one clk wide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame       <= '0;
        end else begin
            line_start  <= ce & h_last;
            frame_start <= ce & h_last & v_last;
            if (ce && h_last && v_last)
                frame <= frame + FW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q <= {(PIPE+1){~HSYNC_POL}};
            vs_q <= {(PIPE+1){~VSYNC_POL}};
            de_q <= '0;
        end else if (ce) begin
            hs_q[0] <= hs_raw;
            vs_q[0] <= vs_raw;
            de_q[0] <= de_raw;
            for (int i = 1; i <= PIPE; i++) begin
                hs_q[i] <= hs_q[i-1];
                vs_q[i] <= vs_q[i-1];
                de_q[i] <= de_q[i-1];
            end
        end
    end

    assign hsync      = hs_q[PIPE];
    assign vsync      = vs_q[PIPE];
    assign display_on = de_q[PIPE];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a PIPE=0 and a PIPE=3 instance on a 16x8 raster,
// checked by checkpoint table, per-clk scoreboard and period counts.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    always #5 clk = ~clk;

    logic [3:0] hpos0, vpos0, hpos3, vpos3, frame0, frame3;
    logic hs0, vs0, de0, ls0, fs0;
    logic hs3, vs3, de3, ls3, fs3;

    vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE(0), .CW(4), .FW(4)) u_p0 (
        .clk(clk), .rst(rst), .ce(ce), .hpos(hpos0), .vpos(vpos0),
        .hsync(hs0), .vsync(vs0), .display_on(de0), .line_start(ls0),
        .frame_start(fs0), .frame(frame0));

    vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE(3), .CW(4), .FW(4)) u_p3 (
        .clk(clk), .rst(rst), .ce(ce), .hpos(hpos3), .vpos(vpos3),
        .hsync(hs3), .vsync(vs3), .display_on(de3), .line_start(ls3),
        .frame_start(fs3), .frame(frame3));

    typedef struct packed {
        logic [3:0] h, v, h3, v3;
        logic hs0, vs0, de0, hs3, vs3, de3, ls, fs, ls3, fs3;
        logic [3:0] fr, fr3;
    } obs_t;

    typedef struct {
        int n;
        logic [3:0] h, v;
        logic hs, vs, de, ls, fs;
        logic [3:0] fr;
    } vec_t;

    int tests = 0;
    int fails = 0;
    obs_t sb_q[$];
    vec_t tbl[16];

    int mh, mv, mfr;
    logic [3:0] mhs, mvs, mde;
    logic mls, mfs;

    function automatic logic raw_hs(int h); return !(h >= 10 && h <= 12); endfunction
    function automatic logic raw_vs(int v); return !(v >= 5 && v <= 6); endfunction
    function automatic logic raw_de(int h, int v); return (h < 8) && (v < 4); endfunction

    task automatic model_reset();
        mh = 0; mv = 0; mfr = 0;
        mhs = 4'hF; mvs = 4'hF; mde = 4'h0;
        mls = 1'b0; mfs = 1'b0;
    endtask

    task automatic model_edge(input logic c);
        if (rst) begin
            model_reset();
        end else if (c) begin
            mhs = {mhs[2:0], raw_hs(mh)};
            mvs = {mvs[2:0], raw_vs(mv)};
            mde = {mde[2:0], raw_de(mh, mv)};
            mls = (mh == 15);
            mfs = (mh == 15) && (mv == 7);
            if (mfs) mfr = (mfr + 1) % 16;
            if (mh == 15) begin
                mh = 0;
                mv = (mv == 7) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end else begin
            mls = 1'b0;
            mfs = 1'b0;
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.h = 4'(mh); o.v = 4'(mv); o.h3 = 4'(mh); o.v3 = 4'(mv);
        o.hs0 = mhs[0]; o.vs0 = mvs[0]; o.de0 = mde[0];
        o.hs3 = mhs[3]; o.vs3 = mvs[3]; o.de3 = mde[3];
        o.ls = mls; o.fs = mfs; o.ls3 = mls; o.fs3 = mfs;
        o.fr = 4'(mfr); o.fr3 = 4'(mfr);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.h = hpos0; o.v = vpos0; o.h3 = hpos3; o.v3 = vpos3;
        o.hs0 = hs0; o.vs0 = vs0; o.de0 = de0;
        o.hs3 = hs3; o.vs3 = vs3; o.de3 = de3;
        o.ls = ls0; o.fs = fs0; o.ls3 = ls3; o.fs3 = fs3;
        o.fr = frame0; o.fr3 = frame3;
        return o;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic c);
        obs_t e;
        ce = c;
        model_edge(c);
        sb_q.push_back(model_obs());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("scoreboard", 64'(dut_obs()), 64'(e));
    endtask

    function automatic vec_t mk(int n, int h, int v, logic hs, logic vs, logic de,
                                logic ls, logic fs, int fr);
        vec_t t;
        t.n = n; t.h = 4'(h); t.v = 4'(v); t.hs = hs; t.vs = vs; t.de = de;
        t.ls = ls; t.fs = fs; t.fr = 4'(fr);
        return t;
    endfunction

    function automatic logic [16:0] pk_dut();
        return {hpos0, vpos0, hs0, vs0, de0, ls0, fs0, frame0};
    endfunction

    function automatic logic [16:0] pk_tbl(vec_t t);
        return {t.h, t.v, t.hs, t.vs, t.de, t.ls, t.fs, t.fr};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ti, hs_low, de_hi, vs_low, nfs, last_fs;
        int fh0, fh3, fd0, fd3, lscnt, last_ls, cnt, k;
        logic pde0, pde3, found;

        // n = ce edges since reset release; outputs reflect position n-1
        tbl[0]  = mk(0,   0,  0, 1, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1,   1,  0, 1, 1, 1, 0, 0, 0);
        tbl[2]  = mk(8,   8,  0, 1, 1, 1, 0, 0, 0);
        tbl[3]  = mk(9,   9,  0, 1, 1, 0, 0, 0, 0);
        tbl[4]  = mk(11,  11, 0, 0, 1, 0, 0, 0, 0);
        tbl[5]  = mk(13,  13, 0, 0, 1, 0, 0, 0, 0);
        tbl[6]  = mk(14,  14, 0, 1, 1, 0, 0, 0, 0);
        tbl[7]  = mk(16,  0,  1, 1, 1, 0, 1, 0, 0);
        tbl[8]  = mk(17,  1,  1, 1, 1, 1, 0, 0, 0);
        tbl[9]  = mk(64,  0,  4, 1, 1, 0, 1, 0, 0);
        tbl[10] = mk(65,  1,  4, 1, 1, 0, 0, 0, 0);
        tbl[11] = mk(81,  1,  5, 1, 0, 0, 0, 0, 0);
        tbl[12] = mk(112, 0,  7, 1, 0, 0, 1, 0, 0);
        tbl[13] = mk(113, 1,  7, 1, 1, 0, 0, 0, 0);
        tbl[14] = mk(128, 0,  0, 1, 1, 0, 1, 1, 1);
        tbl[15] = mk(129, 1,  0, 1, 1, 1, 0, 0, 1);

        model_reset();
        rst = 1'b1;
        ce  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'(dut_obs()), 64'(model_obs()));

        @(negedge clk);
        rst = 1'b0;
        check("tbl_n0", 64'(pk_dut()), 64'(pk_tbl(tbl[0])));
        ti = 1;
        hs_low = 0; de_hi = 0; vs_low = 0; nfs = 0; last_fs = -1;
        fh0 = -1; fh3 = -1; fd0 = -1; fd3 = -1;
        pde0 = de0; pde3 = de3;

        for (int n = 1; n <= 2048; n++) begin
            step(1'b1);
            if (ti < 16 && tbl[ti].n == n) begin
                check($sformatf("tbl_n%0d", n), 64'(pk_dut()), 64'(pk_tbl(tbl[ti])));
                ti++;
            end
            if (n <= 128) begin
                if (!hs0) hs_low++;
                if (de0)  de_hi++;
                if (!vs0) vs_low++;
            end
            if (fs0) begin
                nfs++;
                if (last_fs >= 0) check("fs_period", 64'(n - last_fs), 64'd128);
                last_fs = n;
            end
            if (fh0 < 0 && !hs0) fh0 = n;
            if (fh3 < 0 && !hs3) fh3 = n;
            if (fd0 < 0 && pde0 && !de0) fd0 = n;
            if (fd3 < 0 && pde3 && !de3) fd3 = n;
            pde0 = de0; pde3 = de3;
            if (n == 1920) check("frame_15", 64'(frame0), 64'd15);
            if (n == 2048) check("frame_wrap", 64'(frame0), 64'd0);
        end
        check("hsync_low_clks", 64'(hs_low), 64'd24);
        check("display_clks", 64'(de_hi), 64'd32);
        check("vsync_low_clks", 64'(vs_low), 64'd32);
        check("frame_starts", 64'(nfs), 64'd16);
        check("first_hs_low_p0", 64'(fh0), 64'd11);
        check("pipe3_hs_shift", 64'(fh3 - fh0), 64'd3);
        check("pipe3_de_shift", 64'(fd3 - fd0), 64'd3);

        // ce asserted one clk in three: line period triples, strobes stay 1 clk
        lscnt = 0; last_ls = -1;
        for (k = 0; k < 144; k++) begin
            step(k % 3 == 0);
            if (ls0) begin
                lscnt++;
                if (last_ls >= 0) check("ls_period_ce3", 64'(k - last_ls), 64'd48);
                last_ls = k;
            end
        end
        check("ls_count_ce3", 64'(lscnt), 64'd3);

        // async reset mid-frame at (12,5)
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(1'b1);
            if (mh == 12 && mv == 5) found = 1'b1;
        end
        check("reach_12_5", 64'(found), 64'd1);
        check("pos_12_5", 64'({hpos0, vpos0}), 64'({4'd12, 4'd5}));
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_reset", 64'(dut_obs()), 64'(model_obs()));
        step(1'b1);
        step(1'b1);
        #2;
        rst = 1'b0;
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b1);
            cnt++;
            if (fs0) found = 1'b1;
        end
        check("fs_after_reset", 64'(cnt), 64'd128);
        check("frame_after_reset", 64'(frame0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
